decode_writeback: RTL and testbench

DECODE_WRITEBACK -- requirements
Module: decode_writeback

---
 rtl/decode_writeback.sv | 124 ++++++++++++
 tb/tb_decode_writeback.sv | 130 +++++++++++++
 2 files changed

// File: rtl/decode_writeback.sv
// Decode and writeback stage for a Y86-64 style core.
// Decodes the register IDs for an instruction and holds the 15-entry register file.
// Register reads are combinational. Writes commit on the rising clock edge when wb_en is high.
module decode_writeback #(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic        wb_en,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [3:0]  dbg_addr,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] dbg_data
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;

  logic [63:0] regs [0:14];

  // Read one register. ID 15 is not storage and reads as zero.
  function automatic logic [63:0] rd(input logic [3:0] id);
    return (id == R_NONE) ? 64'd0 : regs[id];
  endfunction

  // Decode the source and destination register IDs from the instruction fields.
  always_comb begin
    // NOTE: every output gets a default first. Without it, the icodes that are
    // not listed would hold the previous value and the tool would infer latches.
    srcA = R_NONE;
    srcB = R_NONE;
    dstE = R_NONE;
    dstM = R_NONE;
    case (icode)
      I_RRMOVQ: begin
        srcA = rA;
        dstE = cnd ? rB : R_NONE;
      end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_RET: begin
        srcA = R_RSP;
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = R_RSP;
        dstE = R_RSP;
      end
      I_POPQ: begin
        srcA = R_RSP;
        srcB = R_RSP;
        dstE = R_RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // Combinational read ports. There is no bypass, so a write shows up only after its edge.
  always_comb begin
    valA     = rd(srcA);
    valB     = rd(srcB);
    dbg_data = rd(dbg_addr);
  end

  // Register file update. Reset has priority over any pending writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this small register file is reset explicitly, because %rsp must
      // start at RSP_INIT. A large RAM would normally be left without a reset.
      for (int i = 0; i < 15; i++)
        regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
    end else if (wb_en) begin
      // NOTE: these are non-blocking assignments. When dstE == dstM, the later
      // valM assignment wins, which is the popq %rsp behaviour.
      if (dstE != R_NONE) regs[dstE] <= valE;
      if (dstM != R_NONE) regs[dstM] <= valM;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Directed self-checking bench for decode_writeback. Expected values are computed by hand.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, rA, rB, dbg_addr;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, dbg_data;

  int checks = 0;
  int errors = 0;

  decode_writeback #(.RSP_INIT(64'h200)) dut (
    .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
    .wb_en(wb_en), .valE(valE), .valM(valM), .dbg_addr(dbg_addr),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for one rising edge, then sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read one register through the debug port.
  task automatic peek(input string tag, input logic [3:0] idx, input logic [63:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Drive one instruction onto the inputs and let the combinational logic settle.
  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; dbg_addr = 4'h0;
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0);
    step();
    rst = 1'b0;

    // Reset contents: every register is zero except %rsp, and ID 15 reads zero.
    for (int i = 0; i < 16; i++)
      peek($sformatf("reset_reg%0d", i), i[3:0], (i == 4) ? 64'h200 : 64'd0);

    // irmovq to register 2, then opq reads register 2 on both ports.
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'hDEAD_BEEF, 64'd0);
    check("irmovq_dstE", dstE, 4'h2);
    check("irmovq_srcA", srcA, 4'hF);
    wb_en = 1'b1; step(); wb_en = 1'b0;
    peek("irmovq_reg2", 4'h2, 64'hDEAD_BEEF);
    drive(4'h6, 4'h2, 4'h2, 1'b0, 64'd0, 64'd0);
    check("opq_valA", valA, 64'hDEAD_BEEF);
    check("opq_valB", valB, 64'hDEAD_BEEF);
    check("opq_dstM", dstM, 4'hF);

    // cmov with cnd=0 writes nothing. With cnd=1 it writes register 3.
    drive(4'h2, 4'h1, 4'h3, 1'b0, 64'h55, 64'd0);
    check("cmov0_dstE", dstE, 4'hF);
    check("cmov0_srcA", srcA, 4'h1);
    wb_en = 1'b1; step(); wb_en = 1'b0;
    peek("cmov0_reg3", 4'h3, 64'd0);
    drive(4'h2, 4'h1, 4'h3, 1'b1, 64'h55, 64'd0);
    check("cmov1_dstE", dstE, 4'h3);
    wb_en = 1'b1; step(); wb_en = 1'b0;
    peek("cmov1_reg3", 4'h3, 64'h55);

    // popq %rsp: when dstE and dstM are both 4, valM wins.
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'h1234);
    check("popq_dstE", dstE, 4'h4);
    check("popq_dstM", dstM, 4'h4);
    check("popq_srcB", srcB, 4'h4);
    wb_en = 1'b1; step(); wb_en = 1'b0;
    peek("popq_reg4", 4'h4, 64'h1234);

    // With wb_en=0, the edge changes nothing.
    drive(4'h3, 4'hF, 4'h6, 1'b0, 64'h99, 64'd0);
    step();
    peek("nowb_reg6", 4'h6, 64'd0);

    // icode C decodes to no reads and no writes.
    drive(4'hC, 4'h1, 4'h2, 1'b1, 64'd0, 64'd0);
    check("icC_srcA", srcA, 4'hF);
    check("icC_srcB", srcB, 4'hF);
    check("icC_dstE", dstE, 4'hF);
    check("icC_dstM", dstM, 4'hF);

    // mrmovq to register 7, then the same write in the same cycle as reset.
    drive(4'h5, 4'h7, 4'h1, 1'b0, 64'd0, 64'h77);
    check("mrmov_dstM", dstM, 4'h7);
    wb_en = 1'b1; step(); wb_en = 1'b0;
    peek("mrmov_reg7", 4'h7, 64'h77);
    drive(4'h5, 4'h7, 4'h1, 1'b0, 64'd0, 64'hAA);
    wb_en = 1'b1; rst = 1'b1; step(); wb_en = 1'b0; rst = 1'b0;
    peek("rstwb_reg7", 4'h7, 64'd0);
    peek("rstwb_reg4", 4'h4, 64'h200);
    peek("rstwb_reg2", 4'h2, 64'd0);

    // Set register 5, then pushq: the old %rsp is visible before the edge and the new one after.
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h5555, 64'd0);
    wb_en = 1'b1; step(); wb_en = 1'b0;
    drive(4'hA, 4'h5, 4'hF, 1'b0, 64'h1F8, 64'd0);
    check("push_pre_valB", valB, 64'h200);
    check("push_pre_valA", valA, 64'h5555);
    check("push_dstE", dstE, 4'h4);
    wb_en = 1'b1; step(); wb_en = 1'b0;
    check("push_post_valB", valB, 64'h1F8);
    check("push_post_valA", valA, 64'h5555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
